// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p
// Two-port arbiter in front of a single-port RAM that has a registered read.
// After reset the block clears every RAM word to zero, one word per cycle
// (INIT). It then enters RUN and grants at most one request per cycle.
// Contested cycles alternate between the ports.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   req0/1, we0/1            request and write-enable for each port
//   addr0/1, wdata0/1        address and write data for each port
//   gnt0/1                   combinational grant for this cycle
//   rvalid0/1, rdata         read response, one cycle after the read grant
//   init_done                high once the clear has finished (RUN state)
//   ram_we/addr/data         command bus to the RAM
//   ram_out                  registered read data from the RAM
module ram_arbiter_2p #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  init_done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    last_gnt_q, last_gnt_d;
  logic                    rvalid0_q, rvalid0_d;
  logic                    rvalid1_q, rvalid1_d;
  logic                    ram_we_c;

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      clr_cnt_q  <= '0;
      last_gnt_q <= 1'b1;  // port 0 wins the first tie
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      last_gnt_q <= last_gnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    last_gnt_d = last_gnt_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    ram_we_c   = 1'b0;
    ram_addr   = '0;
    ram_data   = '0;
    case (state_q)
      ST_INIT: begin
        ram_we_c  = 1'b1;
        ram_addr  = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + CNT_ONE;  // wraps to 0 on the last word
        if (&clr_cnt_q) state_d = ST_RUN;
      end
      default: begin
        // Under contention the port that did not win last time is granted.
        if (req0 && (!req1 || last_gnt_q)) begin
          gnt0       = 1'b1;
          last_gnt_d = 1'b0;
          ram_we_c   = we0;
          ram_addr   = addr0;
          ram_data   = wdata0;
          rvalid0_d  = ~we0;
        end else if (req1) begin
          gnt1       = 1'b1;
          last_gnt_d = 1'b1;
          ram_we_c   = we1;
          ram_addr   = addr1;
          ram_data   = wdata1;
          rvalid1_d  = ~we1;
        end
      end
    endcase
  end

  // The state is already INIT while rst is high, but INIT drives ram_we=1.
  // Masking it here keeps any write from reaching the RAM during reset.
  assign ram_we    = ram_we_c & ~rst;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = ram_out;
  assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_ram_arbiter_2p.sv
module tb_ram_arbiter_2p;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic       gnt0, gnt1, rvalid0, rvalid1, init_done, ram_we;
  logic [7:0] rdata, ram_addr, ram_data;
  logic [7:0] ram_out;
  logic [7:0] mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural single-port RAM: registered read, output held on write cycles.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    else        ram_out <= mem[ram_addr];
  end

  ram_arbiter_2p #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .init_done(init_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_out(ram_out)
  );

  task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask

  // Pulse reset and wait for the clear to finish; a timeout counts as a failure.
  task automatic reset_and_init();
    int n;
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!init_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!init_done) begin
      errors++;
      $display("FAIL init_timeout: init_done=%0b after %0d cycles, required 1", init_done, n);
    end
  endtask

  task automatic test_reset();
    int cnt;
    idle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %0b want 0", init_done); end
    checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b want 00", {gnt0, gnt1}); end
    checks++; if ({rvalid0, rvalid1} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {rvalid0, rvalid1}); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %0b want 0", ram_we); end
    rst = 1'b0;
    #1;
    checks++; if ({ram_we, ram_addr, ram_data} !== {1'b1, 8'h00, 8'h00}) begin errors++;
      $display("FAIL init_first_cmd: we=%0b addr=%h data=%h want 1/00/00", ram_we, ram_addr, ram_data); end
    cnt = 0;
    while (!init_done && cnt < 400) begin
      @(posedge clk);
      cnt++;
      #1;
    end
    checks++; if (cnt !== 256) begin errors++; $display("FAIL init_len: got %0d cycles want 256", cnt); end
    $display("reset: init_done after %0d cycles", cnt);
  endtask

  task automatic test_cleared_reads();
    logic [7:0] addrs [3];
    addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 0, addrs[i], 8'h00, 0, 0, 8'h00, 8'h00);
      #1;
      checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL clr_gnt0: addr=%h got %0b want 1", addrs[i], gnt0); end
      @(negedge clk);
      idle();
      checks++; if ({rvalid0, rdata} !== {1'b1, 8'h00}) begin errors++;
        $display("FAIL clr_read: addr=%h rvalid0=%0b rdata=%h want 1/00", addrs[i], rvalid0, rdata); end
      $display("cleared read addr=%h rdata=%h", addrs[i], rdata);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
    #1;
    checks++; if ({gnt0, gnt1, ram_we, ram_addr, ram_data} !== {3'b101, 8'h10, 8'hA5}) begin errors++;
      $display("FAIL wr_cmd: g0=%0b g1=%0b we=%0b addr=%h data=%h want 1/0/1/10/a5", gnt0, gnt1, ram_we, ram_addr, ram_data); end
    @(negedge clk);
    drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    #1;
    checks++; if ({gnt0, ram_we, rvalid0, rvalid1} !== 4'b1000) begin errors++;
      $display("FAIL rd_cmd: g0=%0b we=%0b rv0=%0b rv1=%0b want 1/0/0/0", gnt0, ram_we, rvalid0, rvalid1); end
    @(negedge clk);
    idle();
    #1;
    checks++; if ({rvalid0, rvalid1, rdata} !== {2'b10, 8'hA5}) begin errors++;
      $display("FAIL raw_read: rv0=%0b rv1=%0b rdata=%h want 1/0/a5", rvalid0, rvalid1, rdata); end
    checks++; if ({ram_we, ram_addr, ram_data} !== 17'h0) begin errors++;
      $display("FAIL idle_bus: we=%0b addr=%h data=%h want 0/00/00", ram_we, ram_addr, ram_data); end
    $display("write/read 0x10: rdata=%h", rdata);
    @(negedge clk);
    checks++; if ({rvalid0, rvalid1} !== 2'b00) begin errors++; $display("FAIL rv_one_cycle: got %b want 00", {rvalid0, rvalid1}); end
  endtask

  task automatic test_back_to_back();
    logic exp_g0, prev_g0;
    logic [7:0] exp_d;
    reset_and_init();
    // Seed distinct data; port 0 then port 1 leaves last_gnt=1 as after reset.
    drive(1, 1, 8'h01, 8'h11, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h22);
    @(negedge clk);
    drive(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
    prev_g0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) idle();
      #1;
      if (k < 4) begin
        exp_g0 = (k % 2 == 0);
        checks++; if ({gnt0, gnt1} !== {exp_g0, ~exp_g0}) begin errors++;
          $display("FAIL b2b_gnt: cycle=%0d got %b want %b", k, {gnt0, gnt1}, {exp_g0, ~exp_g0}); end
        $display("b2b cycle %0d: gnt0=%0b gnt1=%0b", k, gnt0, gnt1);
      end
      if (k > 0) begin
        exp_d = prev_g0 ? 8'h11 : 8'h22;
        checks++; if ({rvalid0, rvalid1, rdata} !== {prev_g0, ~prev_g0, exp_d}) begin errors++;
          $display("FAIL b2b_rv: cycle=%0d rv0=%0b rv1=%0b rdata=%h want %0b/%0b/%h", k, rvalid0, rvalid1, rdata, prev_g0, ~prev_g0, exp_d); end
      end
      prev_g0 = (k % 2 == 0);
      @(negedge clk);
    end
  endtask

  task automatic test_collision();
    // A port-0 access leaves last_gnt=0, so port 1 wins the next tie.
    drive(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    drive(1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 8'h3C);
    #1;
    checks++; if ({gnt0, gnt1, ram_we, ram_data} !== {3'b011, 8'h3C}) begin errors++;
      $display("FAIL coll_first: g0=%0b g1=%0b we=%0b data=%h want 0/1/1/3c", gnt0, gnt1, ram_we, ram_data); end
    @(negedge clk);
    drive(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL coll_second: got %b want 10", {gnt0, gnt1}); end
    @(negedge clk);
    idle();
    checks++; if ({rvalid0, rdata} !== {1'b1, 8'h3C}) begin errors++;
      $display("FAIL coll_read: rv0=%0b rdata=%h want 1/3c", rvalid0, rdata); end
    $display("collision: port0 read 0x20 rdata=%h", rdata);
  endtask

  task automatic test_reset_mid_init();
    int cnt;
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if ({ram_we, ram_addr} !== {1'b1, 8'd100}) begin errors++;
      $display("FAIL mid_init_addr: we=%0b addr=%0d want 1/100", ram_we, ram_addr); end
    rst = 1'b1;
    #1;
    checks++; if ({ram_we, init_done, gnt0, gnt1} !== 4'b0000) begin errors++;
      $display("FAIL mid_init_rst: we=%0b done=%0b g0=%0b g1=%0b want 0000", ram_we, init_done, gnt0, gnt1); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({ram_we, ram_addr} !== {1'b1, 8'h00}) begin errors++;
      $display("FAIL restart_addr: we=%0b addr=%h want 1/00", ram_we, ram_addr); end
    cnt = 0;
    while (!init_done && cnt < 400) begin
      @(posedge clk);
      cnt++;
      #1;
    end
    checks++; if (cnt !== 256) begin errors++; $display("FAIL restart_len: got %0d want 256", cnt); end
    $display("reset mid-init: restart took %0d cycles", cnt);
  endtask

  task automatic test_reset_after_read();
    @(negedge clk);
    drive(1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00);
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rar_gnt: got %0b want 1", gnt0); end
    @(posedge clk);
    rst = 1'b1;
    idle();
    #1;
    checks++; if ({rvalid0, rvalid1} !== 2'b00) begin errors++; $display("FAIL rar_rvalid: got %b want 00", {rvalid0, rvalid1}); end
    @(negedge clk);
    checks++; if ({rvalid0, rvalid1, ram_we} !== 3'b000) begin errors++;
      $display("FAIL rar_hold: rv=%b we=%0b want 00/0", {rvalid0, rvalid1}, ram_we); end
    rst = 1'b0;
    $display("reset after read: rvalid0=%0b", rvalid0);
  endtask

  initial begin
    test_reset();
    test_cleared_reads();
    test_write_read();
    test_back_to_back();
    test_collision();
    test_reset_mid_init();
    test_reset_after_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
